// File: rtl/mul_sequencer.sv
// Multi-cycle shift-and-add 64x64 multiplier (low 64 bits) that borrows the shared
// execute-stage ALU adder while running and stalls the pipeline via busy.
module mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  input  logic        flush,
  input  logic [63:0] AluResultIn,
  output logic        AluOwn,
  output logic [63:0] AluSrcA,
  output logic [63:0] AluSrcB,
  output logic [3:0]  AluCtrl,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT       stateQ, stateD;
  logic [63:0] accQ, accD;
  logic [63:0] mcandQ, mcandD;
  logic [63:0] mplierQ, mplierD;
  logic [5:0]  iterQ, iterD;
  logic [63:0] resultQ, resultD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= StIdle;
      accQ    <= '0;
      mcandQ  <= '0;
      mplierQ <= '0;
      iterQ   <= '0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      accQ    <= accD;
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      iterQ   <= iterD;
      resultQ <= resultD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    accD    = accQ;
    mcandD  = mcandQ;
    mplierD = mplierQ;
    iterD   = iterQ;
    resultD = resultQ;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          accD    = '0;
          mcandD  = op_a;
          mplierD = op_b;
          iterD   = '0;
          if (op_b != 64'd0) begin
            stateD = StRun;
          end else begin
            stateD  = StDone;
            resultD = '0;
          end
        end
      end
      StRun: begin
        if (mplierQ[0]) accD = AluResultIn;
        mcandD  = mcandQ << 1;
        mplierD = mplierQ >> 1;
        iterD   = iterQ + 6'd1;
        // Stop as soon as no set multiplier bits remain to avoid idle add cycles.
        if ((mplierQ >> 1) == 64'd0 || iterQ == 6'd63) begin
          stateD  = StDone;
          resultD = mplierQ[0] ? AluResultIn : accQ;
        end
      end
      StDone: stateD = StIdle;
      default: stateD = StIdle;
    endcase
    // Flush abandons the operation without touching the datapath or result.
    if (flush) begin
      stateD  = StIdle;
      accD    = accQ;
      mcandD  = mcandQ;
      mplierD = mplierQ;
      iterD   = iterQ;
      resultD = resultQ;
    end
  end

  always_comb begin
    AluOwn  = (stateQ == StRun);
    AluSrcA = AluOwn ? accQ : 64'd0;
    AluSrcB = AluOwn ? mcandQ : 64'd0;
    AluCtrl = 4'b0000;
    busy    = (stateQ != StIdle);
    done    = (stateQ == StDone);
    result  = resultQ;
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed scenarios with literal expectations plus random
// traffic checked every cycle against a product/latency model.
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [63:0] opA, opB, aluResult;
  logic        aluOwn, busy, done;
  logic [63:0] aluSrcA, aluSrcB, result;
  logic [3:0]  aluCtrl;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  mul_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (opA),
    .op_b       (opB),
    .flush      (flush),
    .AluResultIn(aluResult),
    .AluOwn     (aluOwn),
    .AluSrcA    (aluSrcA),
    .AluSrcB    (aluSrcB),
    .AluCtrl    (aluCtrl),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  // Shared ALU stand-in: ADD only.
  assign aluResult = aluSrcA + aluSrcB;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op runs (msb(b)+1) cycles then one done cycle.
  localparam int MIdle = 0, MRun = 1, MDone = 2;
  int          mMode = MIdle;
  int          mStep, mSteps;
  logic [63:0] mA, mB, mRes = '0;

  function automatic int msbIndex(input logic [63:0] v);
    int k = -1;
    for (int i = 0; i < 64; i++) if (v[i]) k = i;
    return k;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mMode = MIdle;
      mRes  = '0;
    end else if (flush) begin
      mMode = MIdle;
    end else begin
      case (mMode)
        MIdle: if (start) begin
          mA = opA;
          mB = opB;
          mStep = 0;
          if (opB == 64'd0) begin
            mMode = MDone;
            mRes  = '0;
          end else begin
            mMode  = MRun;
            mSteps = msbIndex(opB) + 1;
          end
        end
        MRun: begin
          mStep++;
          if (mStep == mSteps) begin
            mMode = MDone;
            mRes  = mA * mB;
          end
        end
        default: mMode = MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      logic [63:0] mask, expA, expB;
      mask = (64'd1 << mStep) - 64'd1;
      expA = (mMode == MRun) ? mA * (mB & mask) : 64'd0;
      expB = (mMode == MRun) ? (mA << mStep) : 64'd0;
      chk("busy", 64'(busy), 64'(mMode != MIdle));
      chk("done", 64'(done), 64'(mMode == MDone));
      chk("AluOwn", 64'(aluOwn), 64'(mMode == MRun));
      chk("AluSrcA", aluSrcA, expA);
      chk("AluSrcB", aluSrcB, expB);
      chk("AluCtrl", 64'(aluCtrl), 64'd0);
      chk("result", result, mRes);
    end
  end

  // Called at a negedge (cycle 0): start high for cycles 0..holdStart.
  task automatic runOp(input logic [63:0] a, input logic [63:0] b, input int holdStart,
                       input int expDone, input logic [63:0] expRes, input int expOwn);
    int doneAt = -1;
    int nDone = 0;
    int nOwn = 0;
    opA = a;
    opB = b;
    start = 1'b1;
    for (int c = 1; c <= expDone + 4; c++) begin
      @(negedge clk);
      if (c > holdStart) start = 1'b0;
      if (done) begin
        nDone++;
        if (doneAt < 0) doneAt = c;
      end
      if (aluOwn) nOwn++;
    end
    chk("doneCycle", 64'(doneAt), 64'(expDone));
    chk("donePulses", 64'(nDone), 64'd1);
    chk("ownCycles", 64'(nOwn), 64'(expOwn));
    chk("product", result, expRes);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    opA = '0;
    opB = '0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    chk("resetResult", result, 64'd0);
    chk("resetBusy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runOp(64'd3, 64'd5, 0, 4, 64'd15, 3);
    runOp(64'h1234, 64'd0, 0, 1, 64'd0, 0);
    runOp('1, '1, 0, 65, 64'd1, 64);
    runOp(64'd3, 64'd5, 3, 4, 64'd15, 3);

    // Flush during a long operation: no done, result keeps 15.
    opA = 64'd7;
    opB = 64'h100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushIdle", 64'(busy), 64'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("flushNoDone", 64'(seen), 64'd0);
    end
    chk("flushHold", result, 64'd15);
    runOp(64'd2, 64'd2, 0, 3, 64'd4, 2);

    // Reset in cycle 2 of an operation.
    opA = 64'd9;
    opB = 64'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstBusy", 64'(busy), 64'd0);
    chk("rstOwn", 64'(aluOwn), 64'd0);
    chk("rstSrcA", aluSrcA, 64'd0);
    chk("rstResult", result, 64'd0);
    rst_n = 1'b1;

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      opA = {$urandom, $urandom};
      opB = {$urandom, $urandom} >> $urandom_range(0, 64);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port start, input, 1, request to multiply op_a by op_b.
REQ-004 SHALL have port op_a, input, 64, multiplicand.
REQ-005 SHALL have port op_b, input, 64, multiplier.
REQ-006 SHALL have port flush, input, 1, abort any operation in progress.
REQ-007 SHALL have port AluResultIn, input, 64, sum returned by the shared execute-stage ALU.
REQ-008 SHALL have port AluOwn, output, 1, high while the sequencer owns the ALU operand/control muxes.
REQ-009 SHALL have port AluSrcA, output, 64, ALU operand A (accumulator).
REQ-010 SHALL have port AluSrcB, output, 64, ALU operand B (shifted multiplicand).
REQ-011 SHALL have port AluCtrl, output, 4, ALU control code, always 4'b0000 (ADD).
REQ-012 SHALL have port busy, output, 1, pipeline stall request, high when state != IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-014 SHALL have port result, output, 64, low 64 bits of op_a*op_b.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE in a registered FSM.
REQ-016 SHALL accept a request only when start=1 and state=IDLE at a rising edge; start in RUN or DONE SHALL be ignored, with no queuing.
REQ-017 On accept, SHALL load acc=0, mcand=op_a, mplier=op_b, iter=0; next state RUN if op_b!=0, else DONE with result=0.
REQ-018 In RUN, SHALL drive AluOwn=1, AluSrcA=acc, AluSrcB=mcand, AluCtrl=ADD; outside RUN, AluOwn=0 and AluSrcA=AluSrcB=0.
REQ-019 Each RUN edge SHALL do: if mplier[0]=1 then acc<=AluResultIn; mcand<=mcand<<1 (bits shifted out discarded); mplier<=mplier>>1 (logical); iter<=iter+1 (6-bit).
REQ-020 SHALL leave RUN for DONE when (mplier>>1)==0 or iter==63 on that edge; the final acc value SHALL be copied to result on the same edge.
REQ-021 Latency: with start high in cycle 0 and highest set bit of op_b at index k, RUN SHALL occupy cycles 1..k+1 and done SHALL be high in cycle k+2; op_b=0 gives done in cycle 1.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-023 result SHALL hold its value until the next DONE, reset, or op_b=0 accept; the product SHALL be modulo 2^64, identical for signed and unsigned operands.
REQ-024 flush=1 at an edge SHALL force IDLE from any state, with no done pulse and result unchanged; flush SHALL take priority over start.
REQ-025 busy SHALL be combinational from state: 0 in IDLE, 1 in RUN and DONE.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE; acc, mcand, mplier, iter and result SHALL be 0; done=busy=AluOwn=0; AluSrcA=AluSrcB=0; AluCtrl=0.
REQ-027 Reset SHALL override flush and start, including in the middle of RUN.

Verification
REQ-028 a=3, b=5, start in cycle 0 -> busy in cycles 1..4, RUN in cycles 1..3, done=1 in cycle 4, result=15.
REQ-029 a=0x1234, b=0 -> done in cycle 1, result=0, AluOwn never high.
REQ-030 a=b=0xFFFF_FFFF_FFFF_FFFF -> 64 RUN cycles, done in cycle 65, result=1.
REQ-031 a=7, b=0x100, flush in cycle 3 -> IDLE in cycle 4, no done pulse, result holds its prior value; a later start with a=2, b=2 -> result=4.
REQ-032 start re-asserted in cycles 1..3 during a=3, b=5 -> ignored, with a single done pulse in cycle 4; rst_n=0 in cycle 2 of a new operation -> all outputs 0 in cycle 3.
